// File: rtl/jedro_1_operand_fetch_pkg.sv
// Shared widths, the x0 index and the operand-fetch state encoding.
package jedro_1_operand_fetch_pkg;

  localparam int JEDRO_REG_ADDR_W = 5;
  localparam int JEDRO_DATA_W     = 32;
  localparam int JEDRO_NUM_REGS   = 1 << JEDRO_REG_ADDR_W;

  localparam logic [JEDRO_REG_ADDR_W-1:0] JEDRO_X0 = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RS1,
    ST_CAP1,
    ST_CAP2,
    ST_OUT
  } of_state_e;

endpackage

// File: rtl/jedro_1_regfile.sv
// Single-port register file: one access per cycle, read data registered one cycle after the address.
// x0 is never written, so every read of x0 returns zero.
module jedro_1_regfile
  import jedro_1_operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = JEDRO_DATA_W,
  parameter int ADDR_WIDTH = JEDRO_REG_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  we_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] <= '0;
      data_o <= '0;
    end else begin
      if (we_i && (addr_i != ADDR_WIDTH'(JEDRO_X0))) mem[addr_i] <= data_i;
      data_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/jedro_1_operand_fetch.sv
// Sequences rs1/rs2 reads over the shared regfile port and presents them to execute; operands are valid
// 3 cycles after acceptance (4 with rs2). Writebacks take the port in IDLE/OUT, otherwise the source must hold.
module jedro_1_operand_fetch
  import jedro_1_operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = JEDRO_DATA_W,
  parameter int ADDR_WIDTH = JEDRO_REG_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                  use_rs2_i,
  output logic                  opr_valid_o,
  input  logic                  opr_ready_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  rf_we_o,
  input  logic [DATA_WIDTH-1:0] rf_data_i
);

  of_state_e             state;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic                  use_rs2_q;
  logic [DATA_WIDTH-1:0] rs1_val_q;
  logic [DATA_WIDTH-1:0] rs2_val_q;
  logic                  opr_valid_q;

  logic port_free;
  logic wb_fire;
  logic req_fire;

  // rstn_i is active-high; while it is asserted every handshake output stays low.
  assign port_free   = !rstn_i && ((state == ST_IDLE) || (state == ST_OUT));
  assign wb_ready_o  = port_free;
  assign req_ready_o = !rstn_i && (state == ST_IDLE) && !wb_valid_i;
  assign wb_fire     = wb_valid_i && port_free;
  assign req_fire    = req_valid_i && req_ready_o;

  assign opr_valid_o = opr_valid_q;
  assign rs1_data_o  = rs1_val_q;
  assign rs2_data_o  = rs2_val_q;

  always_comb begin
    rf_addr_o = '0;
    rf_data_o = '0;
    rf_we_o   = 1'b0;
    if (wb_fire) begin
      rf_addr_o = wb_addr_i;
      rf_data_o = wb_data_i;
      rf_we_o   = (wb_addr_i != ADDR_WIDTH'(JEDRO_X0));
    end else if (!rstn_i && (state == ST_RS1)) begin
      rf_addr_o = rs1_q;
    end else if (!rstn_i && (state == ST_CAP1) && use_rs2_q) begin
      rf_addr_o = rs2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state       <= ST_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_rs2_q   <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      opr_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            rs1_q     <= rs1_addr_i;
            rs2_q     <= rs2_addr_i;
            use_rs2_q <= use_rs2_i;
            state     <= ST_RS1;
          end
        end
        ST_RS1: state <= ST_CAP1;
        ST_CAP1: begin
          rs1_val_q <= rf_data_i;
          if (use_rs2_q) begin
            state <= ST_CAP2;
          end else begin
            rs2_val_q   <= '0;
            opr_valid_q <= 1'b1;
            state       <= ST_OUT;
          end
        end
        ST_CAP2: begin
          rs2_val_q   <= rf_data_i;
          opr_valid_q <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (opr_ready_i) begin
            opr_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_operand_fetch.sv
// Operand fetch driving the real regfile: vector table, corner sequences and random traffic vs a register-array model.
module tb_jedro_1_operand_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rf_rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        use_rs2;
  logic        opr_valid;
  logic        opr_ready;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [31:0] rf_rdata;

  always #5 clk = ~clk;

  jedro_1_operand_fetch dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .use_rs2_i  (use_rs2),
    .opr_valid_o(opr_valid),
    .opr_ready_i(opr_ready),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .wb_valid_i (wb_valid),
    .wb_ready_o (wb_ready),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rf_addr_o  (rf_addr),
    .rf_data_o  (rf_wdata),
    .rf_we_o    (rf_we),
    .rf_data_i  (rf_rdata)
  );

  jedro_1_regfile u_rf (
    .clk_i (clk),
    .rst_i (rf_rst),
    .addr_i(rf_addr),
    .data_i(rf_wdata),
    .we_i  (rf_we),
    .data_o(rf_rdata)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model_regs [32];

  typedef struct {
    bit          is_wb;
    logic [4:0]  a;
    logic [4:0]  b;
    bit          use2;
    logic [31:0] data;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left just after a rising edge; the port must be free (IDLE or OUT).
  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(negedge clk);
    chk("wb_ready", 32'(wb_ready), 32'd1);
    chk("wb_we", 32'(rf_we), 32'(a != 5'd0));
    if (a != 5'd0) begin
      chk("wb_addr", 32'(rf_addr), 32'(a));
      chk("wb_data", rf_wdata, d);
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    if (a != 5'd0) model_regs[a] = d;
  endtask

  // Returns at the falling edge of the first cycle with opr_valid high; lat counts from acceptance.
  task automatic start_req(input logic [4:0] a, input logic [4:0] b, input bit u, output int lat);
    int n;
    req_valid = 1'b1;
    rs1_addr  = a;
    rs2_addr  = b;
    use_rs2   = u;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      failures++;
      $display("FAIL req_accept_timeout: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!opr_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    if (!opr_valid) begin
      failures++;
      $display("FAIL opr_valid_timeout: opr_valid stayed %b, required 1", opr_valid);
    end
  endtask

  task automatic finish_req();
    opr_ready = 1'b1;
    @(posedge clk); #1;
    opr_ready = 1'b0;
    chk("opr_valid_drop", 32'(opr_valid), 32'd0);
  endtask

  task automatic do_req(input logic [4:0] a, input logic [4:0] b, input bit u,
                        input logic [31:0] e1, input logic [31:0] e2);
    int lat;
    start_req(a, b, u, lat);
    chk("latency", 32'(lat), u ? 32'd4 : 32'd3);
    chk("rs1_data", rs1_data, e1);
    chk("rs2_data", rs2_data, e2);
    finish_req();
  endtask

  task automatic model_req(input logic [4:0] a, input logic [4:0] b, input bit u);
    do_req(a, b, u, model_regs[a], u ? model_regs[b] : 32'd0);
  endtask

  initial begin
    int lat;
    int stale;
    logic [31:0] h1;
    logic [31:0] h2;

    vecs[0] = '{1, 5'd5,  5'd0,  0, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{0, 5'd5,  5'd0,  1, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2] = '{0, 5'd5,  5'd3,  0, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[3] = '{1, 5'd0,  5'd0,  0, 32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[4] = '{0, 5'd0,  5'd5,  1, 32'h0,        32'h0,        32'hDEADBEEF};
    vecs[5] = '{1, 5'd31, 5'd0,  0, 32'hA5A50001, 32'h0,        32'h0};
    vecs[6] = '{0, 5'd31, 5'd31, 1, 32'h0,        32'hA5A50001, 32'hA5A50001};
    vecs[7] = '{0, 5'd0,  5'd0,  0, 32'h0,        32'h0,        32'h0};

    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    rstn = 1'b1; rf_rst = 1'b1;
    req_valid = 0; rs1_addr = 0; rs2_addr = 0; use_rs2 = 0; opr_ready = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_opr_valid", 32'(opr_valid), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0; rf_rst = 1'b0;
    @(negedge clk);
    chk("idle_opr_valid", 32'(opr_valid), 32'd0);
    chk("idle_rs1", rs1_data, 32'd0);
    chk("idle_rs2", rs2_data, 32'd0);
    chk("idle_rf_we", 32'(rf_we), 32'd0);
    chk("idle_rf_addr", 32'(rf_addr), 32'd0);
    chk("idle_rf_data", rf_wdata, 32'd0);
    chk("idle_wb_ready", 32'(wb_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wb) do_wb(vecs[i].a, vecs[i].data);
      else do_req(vecs[i].a, vecs[i].b, vecs[i].use2, vecs[i].exp1, vecs[i].exp2);
    end

    // Writeback and request presented together: writeback wins, read sees the new value
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
    req_valid = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd0; use_rs2 = 1'b0;
    @(negedge clk);
    chk("prio_req_ready", 32'(req_ready), 32'd0);
    chk("prio_wb_ready", 32'(wb_ready), 32'd1);
    chk("prio_rf_we", 32'(rf_we), 32'd1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    model_regs[7] = 32'h12345678;
    do_req(5'd7, 5'd0, 1'b0, 32'h12345678, 32'h0);

    // Consumer stalls in OUT while a writeback to x5 goes through
    h1 = model_regs[5];
    h2 = model_regs[7];
    start_req(5'd5, 5'd7, 1'b1, lat);
    chk("hold_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    do_wb(5'd5, 32'h1);
    @(negedge clk);
    chk("hold_valid", 32'(opr_valid), 32'd1);
    chk("hold_rs1", rs1_data, h1);
    chk("hold_rs2", rs2_data, h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_valid2", 32'(opr_valid), 32'd1);
    chk("hold_rs1b", rs1_data, h1);
    finish_req();
    do_req(5'd5, 5'd0, 1'b0, 32'h1, 32'h0);

    // Reset while reading rs2 in CAP1
    req_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd7; use_rs2 = 1'b1;
    @(negedge clk);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cap1_rf_addr", 32'(rf_addr), 32'd7);
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_opr_valid", 32'(opr_valid), 32'd0);
    chk("mid_rs1", rs1_data, 32'd0);
    chk("mid_rs2", rs2_data, 32'd0);
    chk("mid_rf_we", 32'(rf_we), 32'd0);
    chk("mid_rf_addr", 32'(rf_addr), 32'd0);
    chk("mid_rf_data", rf_wdata, 32'd0);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (opr_valid) stale++;
    end
    chk("no_stale_operand", 32'(stale), 32'd0);
    @(posedge clk); #1;
    model_req(5'd5, 5'd7, 1'b1);

    // Random traffic against the register-array model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 40) begin
        do_wb(5'($urandom_range(0, 31)), $urandom);
      end else begin
        model_req(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jedro_1_operand_fetch.md
Name: jedro_1_operand_fetch

Overview:
- Sits directly upstream of jedro_1_regfile, a single-port register file with one-cycle registered read data.
- Takes operand read requests (rs1 and optional rs2) and writeback requests (rd, data).
- Drives one shared port on the regfile, one access at a time. Reads are sequenced and captured.
- Delivers an operand pair to the execute stage over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDR_WIDTH, 5, register index width; 32 registers, x0 hardwired to zero.

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rstn_i  in  1  reset: synchronous, active-high (asserted at 1 despite the name)
- req_valid_i  in  1  operand read request valid
- req_ready_o  out  1  request accepted when valid && ready
- rs1_addr_i  in  ADDR_WIDTH  first source register
- rs2_addr_i  in  ADDR_WIDTH  second source register
- use_rs2_i  in  1  1 = fetch rs2; 0 = rs2_data_o forced to 0
- opr_valid_o  out  1  operands valid
- opr_ready_i  in  1  consumer takes operands
- rs1_data_o  out  DATA_WIDTH  captured rs1 value
- rs2_data_o  out  DATA_WIDTH  captured rs2 value
- wb_valid_i  in  1  writeback request valid
- wb_ready_o  out  1  writeback accepted when valid && ready
- wb_addr_i  in  ADDR_WIDTH  destination register
- wb_data_i  in  DATA_WIDTH  writeback data
- rf_addr_o  out  ADDR_WIDTH  regfile address
- rf_data_o  out  DATA_WIDTH  regfile write data
- rf_we_o  out  1  regfile write enable
- rf_data_i  in  DATA_WIDTH  regfile read data; valid the cycle after the address is presented with we=0

Behaviour:
- States: IDLE, RS1, CAP1, CAP2, OUT. Request fields are registered on acceptance.
- IDLE:
  - wb_ready_o=1.
  - req_ready_o = !wb_valid_i; writeback has priority over a read request in the same cycle.
  - Request accepted -> RS1.
- RS1: rf_addr_o=rs1, rf_we_o=0 -> CAP1.
- CAP1:
  - Capture rf_data_i into rs1 at the cycle end.
  - If use_rs2: rf_addr_o=rs2, rf_we_o=0, -> CAP2.
  - Else: rs2 captured as 0, -> OUT.
- CAP2: capture rf_data_i into rs2 -> OUT.
- OUT:
  - opr_valid_o=1; rs1_data_o/rs2_data_o held stable.
  - opr_ready_i -> IDLE.
  - wb_ready_o=1 here too; the port is free because the operands are already captured.
- Latency, with acceptance in cycle 0: opr_valid_o high in cycle 4 with rs2, cycle 3 without. Throughput: one request per 4 or 5 cycles.
- Writeback:
  - Single cycle: rf_addr_o=wb_addr_i, rf_data_o=wb_data_i, rf_we_o=1 combinationally in the accepting cycle.
  - wb_ready_o=0 in RS1/CAP1/CAP2; the source must hold.
- Writeback with wb_addr_i=0: accepted, but rf_we_o stays 0 (x0 is never written).
- Reads of x0 return the regfile value, which is always 0.
- Ordering: a writeback accepted in IDLE in the same cycle as a pending request completes before the read. The subsequent read returns the new value; no forwarding is needed.
- No port conflict is possible: rf_we_o=1 only in IDLE/OUT, and reads happen only in RS1/CAP1.
- Idle port outputs: rf_we_o=0, rf_addr_o=0, rf_data_o=0.
- Reset, including mid-operation:
  - State IDLE; captured operands 0; all outputs 0.
  - Any in-flight request is dropped; opr_valid_o is low the cycle after reset is sampled.
- An incomplete handshake is never lost: the request stays registered until OUT completes.

Decomposition:
- Shared package/defines: state encoding, JEDRO_REG_ADDR_W=5, JEDRO_DATA_W=32, X0 index constant.
- No sub-module. Single FSM plus capture registers.
- The bench instantiates jedro_1_regfile as the real load.

Test Plan:
- Write x5=0xDEADBEEF, then request rs1=5, rs2=0, use_rs2=1 -> opr_valid_o in cycle 4 with rs1=0xDEADBEEF, rs2=0.
- Request rs1=5 with use_rs2=0 -> opr_valid_o in cycle 3, rs2_data_o=0.
- wb_valid_i (x7=0x12345678) and req_valid_i (rs1=7) in the same IDLE cycle -> wb accepted first, req_ready_o=0 that cycle; read returns 0x12345678.
- Writeback x0=0xFFFFFFFF -> wb_ready_o=1, rf_we_o=0; a later read of x0 returns 0.
- Hold opr_ready_i=0 for 3 cycles in OUT while a writeback to x5=0x1 is accepted -> operands unchanged, wb completes; the next read of x5 returns 0x1.
- Assert rstn_i=1 during CAP1 -> IDLE next cycle, opr_valid_o=0, all outputs 0; no stale operand appears afterwards.
